// File: rtl/fsm_divert_bench.sv
// ============================================================================
// fsm_divert_bench
// ----------------------------------------------------------------------------
// Purpose:
//   Moore control FSM with a vector condition bus, a one-hot registered output
//   bus and a saturating event counter.  When built with the macro
//   FSM_DIVERT_EN defined, a DECODE that would normally emit is diverted into
//   WAIT once the event counter has reached THRESH, and 'diverted' pulses.
//   Without the macro there is no diversion path and 'diverted' is tied low.
//
// Parameters:
//   NIN    - width of condition bus x (>= 8)
//   NOUT   - width of output bus y (2..16)
//   THRESH - event count at which diversion becomes active (1..2^CNT_W-1)
//   CNT_W  - event counter width
//
// Ports:
//   clk      in   1      clock, all state updates on rising edge
//   rst      in   1      asynchronous reset, active low
//   in_vld   in   1      x is valid this cycle
//   cnt_clr  in   1      synchronous clear of the event counter
//   x        in   NIN    condition inputs
//   y        out  NOUT   one-hot / zero output code, driven from flops
//   state_o  out  3      current state (IDLE=0 DECODE=1 EMIT=2 WAIT=3 HOLD=4)
//   evt_cnt  out  CNT_W  saturating event counter
//   diverted out  1      one-cycle pulse in the WAIT cycle entered by diversion
//
// Configuration macro: FSM_DIVERT_EN
// ============================================================================
module fsm_divert_bench #(
    parameter int NIN    = 16,
    parameter int NOUT   = 11,
    parameter int THRESH = 5,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic              cnt_clr,
    input  logic [NIN-1:0]    x,
    output logic [NOUT-1:0]   y,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic              diverted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EMIT   = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    // Output codes for WAIT (lowest bit) and HOLD (highest bit); EMIT shifts
    // the lowest-bit code up by the selected index.
    localparam logic [NOUT-1:0]  Y_LSB    = {{(NOUT-1){1'b0}}, 1'b1};
    localparam logic [NOUT-1:0]  Y_MSB    = {1'b1, {(NOUT-1){1'b0}}};
    localparam logic [4:0]       NOUT_V   = 5'(NOUT);
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

    state_t           r_state;
    logic [3:0]       r_sel;
    logic [NOUT-1:0]  r_y;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       w_sel;
    logic             w_selInRange;
    logic             w_decAccept;
    logic             w_countEvt;
    logic             w_atThresh;
    logic             w_divert;
    logic             w_unused;

    // Decode-time qualifiers: an accepted DECODE with an in-range select is
    // an event, whether it ends up emitting or being diverted.
    assign w_sel        = x[7:4];
    assign w_selInRange = ({1'b0, w_sel} < NOUT_V);
    assign w_decAccept  = (r_state == S_DECODE) && in_vld;
    assign w_countEvt   = w_decAccept && w_selInRange;
    assign w_atThresh   = (r_cnt >= THRESH_V);

`ifdef FSM_DIVERT_EN
    logic r_diverted;

    // Divert decision uses the counter value before this event's increment.
    assign w_divert = w_countEvt && w_atThresh;

    // The pulse lines up with the first WAIT cycle and drops on the next edge
    // even if the FSM stays in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_diverted <= 1'b0;
        end else begin
            r_diverted <= w_divert;
        end
    end

    assign diverted = r_diverted;
    assign w_unused = &{1'b0, x, r_sel};
`else
    assign w_divert = 1'b0;
    assign diverted = 1'b0;
    // Inputs and state not consumed in this build are gathered here so the
    // threshold compare and the upper condition bits stay visibly intentional.
    assign w_unused = &{1'b0, x, r_sel, w_atThresh};
`endif

    // Main FSM.  y is loaded at the same edge as the state it belongs to, so
    // a state change and its output code become visible together and y comes
    // straight from flops.  in_vld low freezes every state except EMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sel   <= 4'd0;
            r_y     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_y <= '0;
                    if (in_vld && x[0]) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (in_vld) begin
                        r_sel <= w_sel;
                        if (w_selInRange && !w_divert) begin
                            r_state <= S_EMIT;
                            r_y     <= Y_LSB << w_sel;
                        end else begin
                            r_state <= S_WAIT;
                            r_y     <= Y_LSB;
                        end
                    end else begin
                        r_y <= '0;
                    end
                end
                S_EMIT: begin
                    if (in_vld && x[3]) begin
                        r_state <= S_HOLD;
                        r_y     <= Y_MSB;
                    end else begin
                        r_state <= S_IDLE;
                        r_y     <= '0;
                    end
                end
                S_WAIT: begin
                    if (in_vld && x[1]) begin
                        r_state <= S_IDLE;
                        r_y     <= '0;
                    end else if (in_vld && x[2]) begin
                        r_state <= S_HOLD;
                        r_y     <= Y_MSB;
                    end else begin
                        r_y <= Y_LSB;
                    end
                end
                S_HOLD: begin
                    if (in_vld && !x[2]) begin
                        r_state <= S_IDLE;
                        r_y     <= '0;
                    end else begin
                        r_y <= Y_MSB;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_y     <= '0;
                end
            endcase
        end
    end

    // Saturating event counter; clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_countEvt && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign y       = r_y;
    assign state_o = r_state;
    assign evt_cnt = r_cnt;

endmodule

// File: tb/tb_fsm_divert_bench.sv
// ============================================================================
// tb_fsm_divert_bench
// ----------------------------------------------------------------------------
// Directed steps followed by a randomized phase, each cycle compared against a
// behavioural model of the control rules (state numbers, select, event count).
// ============================================================================
module tb_fsm_divert_bench;

    localparam int NIN    = 16;
    localparam int NOUT   = 11;
    localparam int THRESH = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

`ifdef FSM_DIVERT_EN
    localparam bit DIVERT_ON = 1'b1;
`else
    localparam bit DIVERT_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_vld;
    logic             cnt_clr;
    logic [NIN-1:0]   x;
    logic [NOUT-1:0]  y;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] evt_cnt;
    logic             diverted;

    int assertCount = 0;
    int failCount   = 0;

    // Model state: spec state numbers, latched select, count, divert pulse.
    int mState = 0;
    int mSel   = 0;
    int mCnt   = 0;
    bit mDiv   = 1'b0;

    fsm_divert_bench #(
        .NIN(NIN), .NOUT(NOUT), .THRESH(THRESH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .cnt_clr(cnt_clr), .x(x),
        .y(y), .state_o(state_o), .evt_cnt(evt_cnt), .diverted(diverted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock edge using the rules in plain terms.
    task automatic modelStep(input bit vld, input bit clr, input logic [NIN-1:0] xv);
        int  sel;
        bit  inRange;
        bit  countIt;
        bit  div;
        int  nxt;
        sel     = int'(xv[7:4]);
        inRange = (sel < NOUT);
        countIt = 1'b0;
        div     = 1'b0;
        nxt     = mState;
        case (mState)
            0: if (vld && xv[0]) nxt = 1;
            1: if (vld) begin
                   mSel    = sel;
                   countIt = inRange;
                   div     = DIVERT_ON && inRange && (mCnt >= THRESH);
                   nxt     = (inRange && !div) ? 2 : 3;
               end
            2: nxt = (vld && xv[3]) ? 4 : 0;
            3: if (vld && xv[1]) nxt = 0;
               else if (vld && xv[2]) nxt = 4;
            4: if (vld && !xv[2]) nxt = 0;
            default: nxt = 0;
        endcase
        if (clr) mCnt = 0;
        else if (countIt && mCnt < CNT_MAX) mCnt = mCnt + 1;
        mDiv   = div;
        mState = nxt;
    endtask

    task automatic modelReset();
        mState = 0;
        mSel   = 0;
        mCnt   = 0;
        mDiv   = 1'b0;
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model.
    task automatic applyStimulus(input bit vld, input bit clr, input logic [NIN-1:0] xv);
        in_vld  = vld;
        cnt_clr = clr;
        x       = xv;
        @(posedge clk);
        modelStep(vld, clr, xv);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [NOUT-1:0]  expY;
        logic [2:0]       expState;
        logic [CNT_W-1:0] expCnt;
        expY = '0;
        case (mState)
            2: expY[mSel]     = 1'b1;
            3: expY[0]        = 1'b1;
            4: expY[NOUT-1]   = 1'b1;
            default: expY = '0;
        endcase
        expState = 3'(mState);
        expCnt   = CNT_W'(mCnt);

        assertCount++;
        assert (state_o === expState) else begin
            failCount++;
            $error("[TB] FAIL %s state_o: observed %0d expected %0d", tag, state_o, expState);
        end
        assertCount++;
        assert (y === expY) else begin
            failCount++;
            $error("[TB] FAIL %s y: observed %h expected %h", tag, y, expY);
        end
        assertCount++;
        assert (evt_cnt === expCnt) else begin
            failCount++;
            $error("[TB] FAIL %s evt_cnt: observed %0d expected %0d", tag, evt_cnt, expCnt);
        end
        assertCount++;
        assert (diverted === mDiv) else begin
            failCount++;
            $error("[TB] FAIL %s diverted: observed %b expected %b", tag, diverted, mDiv);
        end
    endtask

    // Accept, decode the given select, then leave EMIT or WAIT for IDLE.
    task automatic runEmit(input int sel, input string tag);
        logic [NIN-1:0] xs;
        xs = '0;
        xs[7:4] = 4'(sel);
        applyStimulus(1'b1, 1'b0, 16'h0001);
        checkOutput({tag, "_accept"});
        applyStimulus(1'b1, 1'b0, xs);
        checkOutput({tag, "_decode"});
        if (mState == 3) applyStimulus(1'b1, 1'b0, 16'h0002);
        else             applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput({tag, "_exit"});
    endtask

    initial begin
        logic [NIN-1:0] xr;
        bit vr;
        bit cr;

        rst     = 1'b0;
        in_vld  = 1'b0;
        cnt_clr = 1'b0;
        x       = '0;
        modelReset();
        #2;
        checkOutput("reset_async");
        @(posedge clk);
        #1;
        checkOutput("reset_held");
        rst = 1'b1;

        // IDLE only leaves on in_vld & x[0]
        applyStimulus(1'b1, 1'b0, 16'h00FE);
        checkOutput("idle_no_x0");
        applyStimulus(1'b0, 1'b0, 16'h0001);
        checkOutput("idle_no_vld");

        // Normal emit of sel=3
        applyStimulus(1'b1, 1'b0, 16'h0001);
        checkOutput("emit_accept");
        applyStimulus(1'b1, 1'b0, 16'h0030);
        checkOutput("emit_sel3");
        assertCount++;
        assert (y === 11'h008) else begin
            failCount++;
            $error("[TB] FAIL emit_sel3_literal y: observed %h expected %h", y, 11'h008);
        end
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("emit_return");

        // Out-of-range select goes to WAIT, counter unchanged
        applyStimulus(1'b1, 1'b0, 16'h0001);
        checkOutput("oor_accept");
        applyStimulus(1'b1, 1'b0, 16'h00C0);
        checkOutput("oor_wait");
        applyStimulus(1'b0, 1'b0, 16'h0002);
        checkOutput("oor_wait_stall");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("oor_wait_stay");
        applyStimulus(1'b1, 1'b0, 16'h0002);
        checkOutput("oor_exit");

        // Stall in DECODE: junk select must not be latched
        applyStimulus(1'b1, 1'b0, 16'h0001);
        checkOutput("stall_accept");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h00F0);
            checkOutput("stall_decode");
        end
        applyStimulus(1'b1, 1'b0, 16'h0050);
        checkOutput("stall_emit");
        applyStimulus(1'b0, 1'b0, 16'h0008);
        checkOutput("stall_emit_leaves");

        // Bring count to THRESH, then the next in-range decode
        for (int i = 0; i < 3; i++) runEmit(i + 1, "pre_thresh");
        runEmit(7, "thresh_decode");
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("thresh_after");

        // Reach HOLD, then reset asynchronously mid-HOLD
        applyStimulus(1'b1, 1'b0, 16'h0001);
        checkOutput("hold_accept");
        applyStimulus(1'b1, 1'b0, 16'h0010);
        checkOutput("hold_decode");
        applyStimulus(1'b1, 1'b0, 16'h000C);
        checkOutput("hold_enter");
        applyStimulus(1'b1, 1'b0, 16'h0004);
        checkOutput("hold_stay");
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("hold_reset_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("post_reset_idle");

        // Saturation over 20 events, then clear coincident with an increment
        for (int i = 0; i < 20; i++) runEmit(i % NOUT, "sat");
        applyStimulus(1'b1, 1'b0, 16'h0001);
        checkOutput("clr_accept");
        applyStimulus(1'b1, 1'b1, 16'h0020);
        checkOutput("clr_with_inc");
        applyStimulus(1'b1, 1'b0, 16'h0002);
        checkOutput("clr_exit");

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            vr = ($urandom_range(0, 9) != 0);
            cr = ($urandom_range(0, 29) == 0);
            xr = NIN'($urandom);
            applyStimulus(vr, cr, xr);
            checkOutput("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
